// File: rtl/conv_channel_ctrl_pkg.sv
// Shared definitions for the ConvChannel sequencer: sizes, bus word types and FSM states.
package conv_channel_ctrl_pkg;

  localparam int unsigned DataWidth   = 32;
  localparam int unsigned KernelSize  = 9;
  localparam int unsigned InputDim    = 4;
  localparam int unsigned AddrWidth   = 8;
  localparam int unsigned CntWidth    = 16;

  localparam int unsigned RowWidth    = $clog2(KernelSize);
  localparam int unsigned WeightWidth = InputDim * DataWidth;
  localparam int unsigned WindowWidth = InputDim * KernelSize * DataWidth;

  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [CntWidth-1:0]    cnt_t;
  typedef logic [RowWidth-1:0]    row_t;
  typedef logic [WeightWidth-1:0] weight_row_t;
  typedef logic [WindowWidth-1:0] window_t;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WFLUSH,
    STREAM,
    WAIT,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/conv_channel_ctrl_if.sv
// Bundle of job, weight-memory, window-stream and ConvChannel signals around the sequencer.
interface conv_channel_ctrl_if;
  import conv_channel_ctrl_pkg::*;

  logic        start;
  cnt_t        num_windows;
  addr_t       wbase_addr;

  logic        wmem_en;
  addr_t       wmem_addr;
  weight_row_t wmem_data;

  window_t     win_data;
  logic        win_valid;
  logic        win_ready;

  weight_row_t weight_in;
  logic        weight_valid;
  window_t     window_in;
  logic        window_valid;
  logic        result_ready;

  logic        busy;
  logic        done;
  cnt_t        result_count;

  // Sequencer side
  modport master (
    input  start, num_windows, wbase_addr, wmem_data, win_data, win_valid, result_ready,
    output wmem_en, wmem_addr, win_ready, weight_in, weight_valid, window_in, window_valid,
           busy, done, result_count
  );

  // Environment side: job issuer, weight SRAM, window source and ConvChannel
  modport slave (
    output start, num_windows, wbase_addr, wmem_data, win_data, win_valid, result_ready,
    input  wmem_en, wmem_addr, win_ready, weight_in, weight_valid, window_in, window_valid,
           busy, done, result_count
  );

endinterface

// File: rtl/conv_channel_ctrl.sv
// Job sequencer for one ConvChannel: weight load from SRAM, window forwarding, result counting.
module conv_channel_ctrl
  import conv_channel_ctrl_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  conv_channel_ctrl_if.master bus
);

  ctrl_state_t state;
  row_t        row_q;
  cnt_t        sent_q;
  cnt_t        num_q;
  weight_row_t weight_hold;

  logic count_en;
  logic xfer;
  cnt_t res_next;

  assign count_en = (state == STREAM) || (state == WAIT) || (state == WFLUSH);
  assign bus.win_ready = (state == STREAM) && (sent_q < num_q);
  assign xfer     = bus.win_valid && bus.win_ready;
  assign res_next = bus.result_count + CntWidth'(count_en && bus.result_ready);

  // The SRAM output register is the single stage between wmem_en and weight_valid,
  // so the live read data is forwarded while valid and held afterwards.
  assign bus.weight_in = bus.weight_valid ? bus.wmem_data : weight_hold;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state            <= IDLE;
      row_q            <= '0;
      sent_q           <= '0;
      num_q            <= '0;
      weight_hold      <= '0;
      bus.wmem_en      <= 1'b0;
      bus.wmem_addr    <= '0;
      bus.weight_valid <= 1'b0;
      bus.window_in    <= '0;
      bus.window_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.result_count <= '0;
    end else begin
      bus.weight_valid <= bus.wmem_en;
      bus.window_valid <= 1'b0;
      bus.done         <= 1'b0;
      bus.result_count <= res_next;
      if (bus.weight_valid) begin
        weight_hold <= bus.wmem_data;
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state            <= WLOAD;
            num_q            <= bus.num_windows;
            row_q            <= '0;
            sent_q           <= '0;
            bus.result_count <= '0;
            bus.wmem_en      <= 1'b1;
            bus.wmem_addr    <= bus.wbase_addr;
            bus.busy         <= 1'b1;
          end
        end

        // One row read per cycle; address wraps naturally at AddrWidth
        WLOAD: begin
          if (row_q == RowWidth'(KernelSize - 1)) begin
            state       <= WFLUSH;
            bus.wmem_en <= 1'b0;
          end else begin
            row_q         <= row_q + RowWidth'(1);
            bus.wmem_addr <= bus.wmem_addr + AddrWidth'(1);
          end
        end

        WFLUSH: begin
          if (num_q == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state <= STREAM;
          end
        end

        STREAM: begin
          if (xfer) begin
            bus.window_in    <= bus.win_data;
            bus.window_valid <= 1'b1;
            sent_q           <= sent_q + CntWidth'(1);
            if (sent_q + CntWidth'(1) == num_q) begin
              state <= WAIT;
            end
          end
        end

        // Completion may coincide with the final result pulse
        WAIT: begin
          if (res_next == num_q) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_channel_ctrl.sv
// Directed bench for conv_channel_ctrl with a synchronous weight SRAM model and a result stub.
module tb_conv_channel_ctrl;
  import conv_channel_ctrl_pkg::*;

  localparam int unsigned WW = WindowWidth;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_channel_ctrl_if bus ();

  conv_channel_ctrl dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  weight_row_t wmem_q  = '0;
  logic        rr_d1   = 1'b0;
  logic        rr_d2   = 1'b0;
  logic        stub_en = 1'b0;
  logic        rr_force = 1'b0;

  logic [7:0] wrap_tab [9] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
  bit         tog      [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  function automatic weight_row_t mem_row(input addr_t a);
    weight_row_t r;
    for (int i = 0; i < int'(InputDim); i++) r[i*DataWidth +: DataWidth] = {8'hA5, a, 8'(i), 8'h3C};
    return r;
  endfunction

  function automatic window_t win_pat(input int c);
    window_t w;
    for (int i = 0; i < int'(InputDim * KernelSize); i++) w[i*DataWidth +: DataWidth] = {8'h5A, 8'(c), 16'(i)};
    return w;
  endfunction

  // Synchronous-read weight SRAM: data one cycle after enable, held otherwise
  always @(posedge clk) if (bus.wmem_en) wmem_q <= mem_row(bus.wmem_addr);
  assign bus.wmem_data = wmem_q;

  // ConvChannel stand-in: result two cycles after each accepted window
  always @(posedge clk) begin
    rr_d1 <= bus.window_valid;
    rr_d2 <= rr_d1;
  end
  assign bus.result_ready = (stub_en && rr_d2) || rr_force;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input addr_t base, input cnt_t num);
    bus.wbase_addr  = base;
    bus.num_windows = num;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    check(tag, WW'(bus.done), WW'(1));
  endtask

  initial begin
    int wv_cnt;
    int done_cnt;
    bus.start = 1'b0; bus.num_windows = '0; bus.wbase_addr = '0;
    bus.win_data = '0; bus.win_valid = 1'b0;
    rst = 1'b1;
    step(); step();

    check("rst wmem_en",      WW'(bus.wmem_en),      WW'(0));
    check("rst wmem_addr",    WW'(bus.wmem_addr),    WW'(0));
    check("rst weight_valid", WW'(bus.weight_valid), WW'(0));
    check("rst weight_in",    WW'(bus.weight_in),    WW'(0));
    check("rst window_valid", WW'(bus.window_valid), WW'(0));
    check("rst window_in",    WW'(bus.window_in),    WW'(0));
    check("rst win_ready",    WW'(bus.win_ready),    WW'(0));
    check("rst busy",         WW'(bus.busy),         WW'(0));
    check("rst done",         WW'(bus.done),         WW'(0));
    check("rst result_count", WW'(bus.result_count), WW'(0));
    rst = 1'b0;
    step();

    // Weight load from 0x10, empty job
    begin_job(8'h10, 16'd0);
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t1 wmem_en c%0d", c), WW'(bus.wmem_en), WW'(c <= 9));
      if (c <= 9) check($sformatf("t1 addr c%0d", c), WW'(bus.wmem_addr), WW'(8'h10 + 8'(c - 1)));
      check($sformatf("t1 weight_valid c%0d", c), WW'(bus.weight_valid), WW'(c >= 2 && c <= 10));
      if (c >= 2 && c <= 10)
        check($sformatf("t1 weight_in c%0d", c), WW'(bus.weight_in), WW'(mem_row(8'h10 + 8'(c - 2))));
      check($sformatf("t1 done c%0d", c), WW'(bus.done), WW'(c == 11));
      check($sformatf("t1 busy c%0d", c), WW'(bus.busy), WW'(c <= 11));
      if (c == 11) check("t1 result_count", WW'(bus.result_count), WW'(0));
      step();
    end

    // Address wrap from 0xFC
    begin_job(8'hFC, 16'd0);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 9) check($sformatf("t2 addr c%0d", c), WW'(bus.wmem_addr), WW'(wrap_tab[c-1]));
      if (c == 12) check("t2 weight_in held", WW'(bus.weight_in), WW'(mem_row(8'h04)));
      step();
    end

    // Four windows, win_valid held, stub answers
    stub_en = 1'b1;
    bus.win_valid = 1'b1;
    wv_cnt = 0;
    done_cnt = 0;
    begin_job(8'h00, 16'd4);
    for (int c = 1; c <= 20; c++) begin
      bus.win_data = win_pat(c);
      check($sformatf("t3 win_ready c%0d", c), WW'(bus.win_ready), WW'(c >= 11 && c <= 14));
      check($sformatf("t3 window_valid c%0d", c), WW'(bus.window_valid), WW'(c >= 12 && c <= 15));
      if (c >= 12 && c <= 15) check($sformatf("t3 window_in c%0d", c), WW'(bus.window_in), WW'(win_pat(c - 1)));
      check($sformatf("t3 done c%0d", c), WW'(bus.done), WW'(c == 18));
      if (bus.window_valid) wv_cnt++;
      if (bus.done) done_cnt++;
      step();
    end
    check("t3 window count", WW'(wv_cnt), WW'(4));
    check("t3 done count", WW'(done_cnt), WW'(1));
    check("t3 result_count", WW'(bus.result_count), WW'(4));
    bus.win_valid = 1'b0;
    stub_en = 1'b0;

    // Three windows with a toggling source, then a refused fourth offer
    wv_cnt = 0;
    begin_job(8'h00, 16'd3);
    for (int c = 1; c <= 20; c++) begin
      bus.win_valid = (c >= 11 && c <= 17) ? tog[c-11] : 1'b0;
      bus.win_data  = win_pat(c);
      check($sformatf("t4 win_ready c%0d", c), WW'(bus.win_ready), WW'(c >= 11 && c <= 15));
      check($sformatf("t4 window_valid c%0d", c), WW'(bus.window_valid), WW'(c == 12 || c == 14 || c == 16));
      if (c == 12 || c == 14 || c == 16)
        check($sformatf("t4 window_in c%0d", c), WW'(bus.window_in), WW'(win_pat(c - 1)));
      if (c >= 17) check($sformatf("t4 window_in held c%0d", c), WW'(bus.window_in), WW'(win_pat(15)));
      if (bus.window_valid) wv_cnt++;
      step();
    end
    check("t4 window count", WW'(wv_cnt), WW'(3));
    bus.win_valid = 1'b0;
    rr_force = 1'b1;
    step(); step(); step();
    rr_force = 1'b0;
    wait_done("t4 done", 5);
    check("t4 result_count", WW'(bus.result_count), WW'(3));
    step();

    // Stray result in IDLE and start during STREAM are ignored
    rr_force = 1'b1;
    step();
    rr_force = 1'b0;
    check("t5 idle result_count", WW'(bus.result_count), WW'(3));
    check("t5 idle busy", WW'(bus.busy), WW'(0));
    begin_job(8'h20, 16'd2);
    for (int c = 1; c <= 18; c++) begin
      if (c == 12) begin
        bus.start = 1'b1; bus.num_windows = 16'd7; bus.wbase_addr = 8'h80;
      end
      if (c == 13) bus.start = 1'b0;
      if (c >= 15) begin
        bus.win_valid = 1'b1;
        stub_en = 1'b1;
        check($sformatf("t5 win_ready c%0d", c), WW'(bus.win_ready), WW'(c <= 16));
      end
      if (c == 13 || c == 14) begin
        check($sformatf("t5 wmem_en c%0d", c), WW'(bus.wmem_en), WW'(0));
        check($sformatf("t5 busy c%0d", c), WW'(bus.busy), WW'(1));
        check($sformatf("t5 result_count c%0d", c), WW'(bus.result_count), WW'(0));
      end
      step();
    end
    wait_done("t5 done", 10);
    check("t5 result_count", WW'(bus.result_count), WW'(2));
    bus.win_valid = 1'b0;
    stub_en = 1'b0;
    step();

    // Reset in WAIT with 2 of 4 results, then a clean job
    bus.win_valid = 1'b1;
    begin_job(8'h30, 16'd4);
    for (int c = 1; c <= 15; c++) begin
      bus.win_data = win_pat(c + 100);
      if (c == 15) bus.win_valid = 1'b0;
      step();
    end
    rr_force = 1'b1;
    step(); step();
    rr_force = 1'b0;
    check("t6 partial result_count", WW'(bus.result_count), WW'(2));
    check("t6 busy in wait", WW'(bus.busy), WW'(1));
    rst = 1'b1;
    step();
    check("t6 rst busy", WW'(bus.busy), WW'(0));
    check("t6 rst result_count", WW'(bus.result_count), WW'(0));
    check("t6 rst done", WW'(bus.done), WW'(0));
    check("t6 rst window_valid", WW'(bus.window_valid), WW'(0));
    check("t6 rst win_ready", WW'(bus.win_ready), WW'(0));
    check("t6 rst wmem_en", WW'(bus.wmem_en), WW'(0));
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t6 no done %0d", c), WW'(bus.done), WW'(0));
    end
    stub_en = 1'b1;
    bus.win_valid = 1'b1;
    bus.win_data = win_pat(200);
    begin_job(8'h40, 16'd1);
    wait_done("t6 rerun done", 30);
    check("t6 rerun result_count", WW'(bus.result_count), WW'(1));
    check("t6 rerun window_in", WW'(bus.window_in), WW'(win_pat(200)));
    bus.win_valid = 1'b0;
    stub_en = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
